// File: rtl/bp_pkg.sv
// Shared types and helpers for the branch predictor: mode encoding, the BTB
// entry layout, the PHT reset value and the 2-bit saturating counter update.
package bp_pkg;

   typedef enum logic [1:0] {
      STATIC  = 2'd0,
      BIMODAL = 2'd1,
      GSHARE  = 2'd2
   } bp_mode_e;

   // Widest datapath the BTB entry layout is sized for (RV32I). Narrower
   // XLEN values are zero-extended into the entry fields.
   localparam int BP_MAX_XLEN = 32;

   // One BTB line. The tag field holds pc >> (IDX+2), zero-extended.
   typedef struct packed {
      logic                   valid;
      logic [BP_MAX_XLEN-1:0] tag;
      logic [BP_MAX_XLEN-1:0] target;
      logic                   jmp;
   } btb_entry_t;

   // Weakly not-taken.
   localparam logic [1:0] PHT_RESET = 2'b01;

   // 2-bit saturating counter step: up on taken, down otherwise, clamped to 0..3.
   function automatic logic [1:0] sat2_update(input logic [1:0] cnt, input logic taken);
      logic [1:0] res;
      if (taken) begin
         res = (cnt == 2'b11) ? cnt : cnt + 2'b01;
      end else begin
         res = (cnt == 2'b00) ? cnt : cnt - 2'b01;
      end
      return res;
   endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// Fetch-query / EX-resolve bundle between the pipeline and the predictor.
// The pipeline side is the master, the predictor is the slave.
interface branch_predictor_if #(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64
);
   localparam int IDX = $clog2(ENTRIES);

   // Fetch-stage query and its combinational answer
   logic [XLEN-1:0] f_pc;
   logic            pred_hit;
   logic            pred_taken;
   logic [XLEN-1:0] pred_next_pc;
   logic [IDX-1:0]  pred_idx;

   // EX-stage resolved outcome plus the prediction carried from fetch
   logic            ex_valid;
   logic            ex_is_br;
   logic            ex_is_jmp;
   logic [XLEN-1:0] ex_pc;
   logic            ex_taken;
   logic [XLEN-1:0] ex_target;
   logic            ex_pred_taken;
   logic [XLEN-1:0] ex_pred_next_pc;
   logic [IDX-1:0]  ex_pred_idx;

   // Flush request and statistics
   logic            mispredict;
   logic [XLEN-1:0] redirect_pc;
   logic [31:0]     br_cnt;
   logic [31:0]     mispred_cnt;

   modport master (
      output f_pc,
      input  pred_hit, pred_taken, pred_next_pc, pred_idx,
      output ex_valid, ex_is_br, ex_is_jmp, ex_pc, ex_taken, ex_target,
      output ex_pred_taken, ex_pred_next_pc, ex_pred_idx,
      input  mispredict, redirect_pc, br_cnt, mispred_cnt
   );

   modport slave (
      input  f_pc,
      output pred_hit, pred_taken, pred_next_pc, pred_idx,
      input  ex_valid, ex_is_br, ex_is_jmp, ex_pc, ex_taken, ex_target,
      input  ex_pred_taken, ex_pred_next_pc, ex_pred_idx,
      output mispredict, redirect_pc, br_cnt, mispred_cnt
   );

endinterface

// File: rtl/bp_btb.sv
// Direct-mapped branch target buffer: one combinational read port for fetch,
// one write port for EX. Only the valid bits are reset; tag/target/jmp are
// plain storage whose stale contents are masked by valid.
module bp_btb
   import bp_pkg::*;
#(
   parameter int ENTRIES = 64
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic [$clog2(ENTRIES)-1:0] rd_idx,
   output btb_entry_t                 rd_entry,
   input  logic                       wr_en,
   input  logic [$clog2(ENTRIES)-1:0] wr_idx,
   input  btb_entry_t                 wr_entry
);
   localparam int IDX = $clog2(ENTRIES);

   logic [ENTRIES-1:0]     valid_reg;
   logic [ENTRIES-1:0]     wr_sel;
   logic [BP_MAX_XLEN-1:0] tag_mem    [ENTRIES];
   logic [BP_MAX_XLEN-1:0] target_mem [ENTRIES];
   logic                   jmp_mem    [ENTRIES];

   // One-hot write decode per line
   generate
      for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_wr_sel
         assign wr_sel[gi] = wr_en && (wr_idx == IDX'(gi));
      end
   endgenerate

   // Valid bits: cleared asynchronously, set by a write to their line
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         valid_reg <= '0;
      end else begin
         for (int i = 0; i < ENTRIES; i++) begin
            if (wr_sel[i]) begin
               valid_reg[i] <= wr_entry.valid;
            end
         end
      end
   end

   // Payload storage; a write landing during reset is harmless because the
   // line's valid bit is held clear
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         tag_mem[wr_idx]    <= wr_entry.tag;
         target_mem[wr_idx] <= wr_entry.target;
         jmp_mem[wr_idx]    <= wr_entry.jmp;
      end
   end

   // Zero-latency read for the fetch stage, no write bypass
   always_comb begin
      rd_entry        = '0;
      rd_entry.valid  = valid_reg[rd_idx];
      rd_entry.tag    = tag_mem[rd_idx];
      rd_entry.target = target_mem[rd_idx];
      rd_entry.jmp    = jmp_mem[rd_idx];
   end

endmodule

// File: rtl/branch_predictor.sv
// Dynamic branch predictor: BTB plus a PHT of 2-bit counters, in static
// not-taken, bimodal or gshare mode. Fetch lookups are combinational; EX
// resolves update the tables on the clock edge and raise a combinational
// mispredict/redirect for the hazard unit.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int ENTRIES = 64,
   parameter int MODE    = 1,
   parameter int GHR_W   = 6
) (
   input logic               clk_i,
   input logic               rst_i,
   branch_predictor_if.slave bus
);
   localparam int       IDX        = $clog2(ENTRIES);
   localparam bp_mode_e MODE_E     = bp_mode_e'(MODE);
   localparam bit       USE_TABLES = (MODE_E != STATIC);

   // Tables
   logic [1:0]       pht_reg [ENTRIES];
   logic [GHR_W-1:0] ghr_reg;
   logic [IDX-1:0]   ghr_ext;

   // Lookup side
   logic [IDX-1:0]   f_idx;
   logic [XLEN-1:0]  f_tag_full;
   logic [IDX-1:0]   lk_pht_idx;
   logic             lk_hit;
   logic             lk_taken;
   logic [XLEN-1:0]  lk_next_pc;
   btb_entry_t       rd_entry;

   // Resolve side
   logic             ctl;
   logic [XLEN-1:0]  correct_pc;
   logic             upd;
   logic             pht_we;
   logic             btb_we;
   logic [IDX-1:0]   wr_idx;
   logic [XLEN-1:0]  ex_tag_full;
   btb_entry_t       wr_entry;
   logic [31:0]      br_cnt_reg;
   logic [31:0]      mispred_cnt_reg;

   // The carried taken bit is implied by the carried next PC
   logic             unused_ok;
   assign unused_ok = &{1'b0, bus.ex_pred_taken};

   assign f_idx       = bus.f_pc[IDX+1:2];
   assign f_tag_full  = bus.f_pc >> (IDX + 2);
   assign ghr_ext     = IDX'(ghr_reg);
   assign wr_idx      = bus.ex_pc[IDX+1:2];
   assign ex_tag_full = bus.ex_pc >> (IDX + 2);

   bp_btb #(
      .ENTRIES (ENTRIES)
   ) u_btb (
      .clk_i    (clk_i),
      .rst_i    (rst_i),
      .rd_idx   (f_idx),
      .rd_entry (rd_entry),
      .wr_en    (btb_we),
      .wr_idx   (wr_idx),
      .wr_entry (wr_entry)
   );

   // Fetch lookup: BTB hit, direction from jmp bit or PHT MSB, next PC
   always_comb begin
      lk_pht_idx = f_idx;
      if (MODE_E == GSHARE) begin
         lk_pht_idx = f_idx ^ ghr_ext;
      end
      lk_hit     = USE_TABLES && rd_entry.valid &&
                   (rd_entry.tag == BP_MAX_XLEN'(f_tag_full));
      lk_taken   = lk_hit && (rd_entry.jmp || pht_reg[lk_pht_idx][1]);
      lk_next_pc = lk_taken ? XLEN'(rd_entry.target) : bus.f_pc + XLEN'(4);
   end

   assign bus.pred_hit     = lk_hit;
   assign bus.pred_taken   = lk_taken;
   assign bus.pred_next_pc = lk_next_pc;
   assign bus.pred_idx     = lk_pht_idx;

   // Resolve: compare the true next PC against what fetch went down
   always_comb begin
      ctl        = bus.ex_valid && (bus.ex_is_br || bus.ex_is_jmp);
      correct_pc = bus.ex_taken ? bus.ex_target : bus.ex_pc + XLEN'(4);
      upd        = ctl && USE_TABLES;
      pht_we     = upd && bus.ex_is_br;
      btb_we     = upd && bus.ex_taken;
      wr_entry        = '0;
      wr_entry.valid  = 1'b1;
      wr_entry.tag    = BP_MAX_XLEN'(ex_tag_full);
      wr_entry.target = BP_MAX_XLEN'(bus.ex_target);
      wr_entry.jmp    = bus.ex_is_jmp;
   end

   assign bus.mispredict  = ctl && (correct_pc != bus.ex_pred_next_pc);
   assign bus.redirect_pc = correct_pc;

   // PHT: train the counter fetch actually used, on conditional branches only
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < ENTRIES; i++) begin
            pht_reg[i] <= PHT_RESET;
         end
      end else if (pht_we) begin
         pht_reg[bus.ex_pred_idx] <= sat2_update(pht_reg[bus.ex_pred_idx], bus.ex_taken);
      end
   end

   // Global history: non-speculative, shifted by resolved conditional branches
   generate
      if (MODE_E == GSHARE && GHR_W > 1) begin : g_ghr
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               ghr_reg <= '0;
            end else if (pht_we) begin
               ghr_reg <= {ghr_reg[GHR_W-2:0], bus.ex_taken};
            end
         end
      end else if (MODE_E == GSHARE) begin : g_ghr_1b
         always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
               ghr_reg <= '0;
            end else if (pht_we) begin
               ghr_reg <= bus.ex_taken;
            end
         end
      end else begin : g_ghr_off
         assign ghr_reg = '0;
      end
   endgenerate

   // Statistics: every resolved control-flow instruction and every flush
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         br_cnt_reg      <= '0;
         mispred_cnt_reg <= '0;
      end else begin
         if (ctl) begin
            br_cnt_reg <= br_cnt_reg + 32'd1;
         end
         if (bus.mispredict) begin
            mispred_cnt_reg <= mispred_cnt_reg + 32'd1;
         end
      end
   end

   assign bus.br_cnt      = br_cnt_reg;
   assign bus.mispred_cnt = mispred_cnt_reg;

endmodule
